// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation select, FSM states
// and the default datapath width.
package mips_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction at load and
// sign correction of results at FIX.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes.
// Optional MULT_DIV_FAST_MUL_EN: single-cycle multiply that skips CALC.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: busy is high from the cycle after an accepted start through the
  // FIX edge; done pulses for one cycle afterwards with busy already low, and a
  // start presented in that cycle is accepted.
  mdu_state_e         state;
  mdu_op_e            op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic               neg_q, rem_neg_q, div_zero_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   rem, quot, divisor;

  mdu_op_e            op_sel;
  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted, diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;

  assign op_sel    = mdu_op_e'(op);
  assign signed_op = (op_sel == MDU_MULT) || (op_sel == MDU_DIV);

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (
    .value(operand_a), .negate(signed_op & operand_a[WIDTH-1]), .result(abs_a)
  );
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (
    .value(operand_b), .negate(signed_op & operand_b[WIDTH-1]), .result(abs_b)
  );
  mdu_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .value(acc), .negate(neg_q), .result(prod_fixed)
  );
  mdu_sign_fix #(.W(WIDTH)) u_quot_fix (
    .value(quot), .negate(neg_q), .result(quot_fixed)
  );
  mdu_sign_fix #(.W(WIDTH)) u_rem_fix (
    .value(rem), .negate(rem_neg_q), .result(rem_fixed)
  );

`ifdef MULT_DIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

  // Shift-add: the multiplier sits in acc's low half and shifts out as the
  // partial product shifts in from the top.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  // Restoring division; a clear diff MSB means the trial subtraction fits.
  assign shifted = {rem, quot[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  assign hi_out = hi;
  assign lo_out = lo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= MDU_IDLE;
      op_q       <= MDU_MULT;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      rem        <= '0;
      quot       <= '0;
      divisor    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (hi_we) hi <= write_data;
          if (lo_we) lo <= write_data;
          if (start) begin
            op_q       <= op_sel;
            neg_q      <= signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            rem_neg_q  <= signed_op & operand_a[WIDTH-1];
            div_zero_q <= (operand_b == '0);
            acc        <= {{WIDTH{1'b0}}, abs_b};
            mcand      <= abs_a;
            rem        <= '0;
            quot       <= abs_a;
            divisor    <= abs_b;
            cnt        <= CW'(WIDTH - 1);
            busy       <= 1'b1;
            state      <= MDU_CALC;
`ifdef MULT_DIV_FAST_MUL_EN
            if (!op_sel[1]) begin
              acc   <= fast_prod;
              state <= MDU_FIX;
            end
`endif
          end
        end
        MDU_CALC: begin
          if (!op_q[1]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            rem  <= diff[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= shifted[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= MDU_FIX;
        end
        MDU_FIX: begin
          if (!op_q[1]) begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end else begin
            // With a zero divisor the remainder path rebuilds the dividend.
            hi <= rem_fixed;
            lo <= div_zero_q ? '1 : quot_fixed;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO vectors, latency,
// MTHI/MTLO, ignored start/write while busy, and reset abort.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] write_data = '0;
  logic         busy, done;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we), .write_data(write_data),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] o);
`ifdef MULT_DIV_FAST_MUL_EN
    if (!o[1]) return 2;
`endif
    return W + 2;
  endfunction

  // Wait for done (entered and left at a negedge); returns edges since start.
  task automatic wait_done(input string tag, input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic score(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_hi"}, 64'(hi_out), 64'(e[2*W-1:W]));
    check({tag, "_lo"}, 64'(lo_out), 64'(e[W-1:0]));
  endtask

  // driver: issue an op (optionally with a same-cycle MTHI), wait and score
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input logic wr_hi, input logic [W-1:0] wd);
    int lat;
    exp_q.push_back({e_hi, e_lo});
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    hi_we = wr_hi; write_data = wd;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0;
    if (wr_hi) check({tag, "_mthi_with_start"}, 64'(hi_out), 64'(wd));
    wait_done(tag, 1, lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_latency(o)));
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    score(tag);
  endtask

  initial begin
    int lat;
    int done_seen;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // MTHI and MTLO together
    hi_we = 1'b1; lo_we = 1'b1; write_data = 32'h0000AAAA;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", 64'(hi_out), 64'h0000AAAA);
    check("mt_both_lo", 64'(lo_out), 64'h0000AAAA);

    run_op("multu_start_mthi", 2'(MDU_MULTU), 32'd3, 32'd3, 32'h0, 32'd9, 1'b1, 32'h55);
    run_op("multu_ff_x2", 2'(MDU_MULTU), 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 1'b0, '0);
    run_op("mult_m1_x2", 2'(MDU_MULT), 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, '0);
    run_op("mult_big", 2'(MDU_MULT), 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, '0);
    run_op("div_m7_2", 2'(MDU_DIV), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, '0);
    run_op("divu_100_7", 2'(MDU_DIVU), 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, '0);
    run_op("divu_5_0", 2'(MDU_DIVU), 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, '0);
    run_op("div_m7_0", 2'(MDU_DIV), 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, '0);
    run_op("div_ovf", 2'(MDU_DIV), 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, '0);

    // start and MTHI while busy are ignored
    exp_q.push_back({32'd2, 32'd14});
    start = 1'b1; op = 2'(MDU_DIVU); operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start = 1'b1; op = 2'(MDU_MULTU); operand_a = 32'd3; operand_b = 32'd3;
    hi_we = 1'b1; write_data = 32'h1234;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0;
    check("busy_ign_busy", 64'(busy), 64'd1);
    check("busy_ign_hi", 64'(hi_out), 64'h0);
    check("busy_ign_lo", 64'(lo_out), 64'h80000000);
    wait_done("busy_ign", 11, lat);
    check("busy_ign_latency", 64'(lat), 64'(W + 2));
    score("busy_ign");
    repeat (3) @(negedge clock);
    check("busy_ign_no_queue", 64'(busy), 64'd0);

    // reset mid-operation
    start = 1'b1; op = 2'(MDU_DIVU); operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi_out), 64'd0);
    check("rst_mid_lo", 64'(lo_out), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clock);
      if (done === 1'b1) done_seen = 1;
    end
    check("rst_mid_no_done", 64'(done_seen), 64'd0);

    // MTLO after reset release
    lo_we = 1'b1; write_data = 32'h0000ABCD;
    @(posedge clock);
    #1;
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo_out), 64'h0000ABCD);
    check("mtlo_hi_kept", 64'(hi_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit holding the architectural HI and LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It sits downstream of `register_file`, taking the rs/rt read ports (`data_out_1`/`data_out_2`) as operands. Its `hi_out`/`lo_out` feed the writeback mux that drives `register_file.write_data_in` for MFHI/MFLO. A `busy`/`done` handshake lets the control unit stall MFHI/MFLO until a result is valid.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low; `reset == 0` clears all state immediately.
- `start`  in  1  launch the operation selected by `op`; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  WIDTH  rs value (multiplicand / dividend).
- `operand_b`  in  WIDTH  rt value (multiplier / divisor).
- `hi_we`  in  1  MTHI: load `write_data` into HI.
- `lo_we`  in  1  MTLO: load `write_data` into LO.
- `write_data`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `hi_out`  out  WIDTH  HI register, driven combinationally from the register.
- `lo_out`  out  WIDTH  LO register, driven combinationally from the register.

## Operation
- **Reset values:** HI=0, LO=0, busy=0, done=0, state IDLE, iteration counter 0.
- **States:**
  - IDLE → CALC on `start`.
  - CALC runs `WIDTH` cycles, with a counter from WIDTH-1 down to 0; CALC → FIX when the counter reaches 0.
  - FIX → IDLE unconditionally.
- **Load (on start in IDLE):**
  - Latch `op`.
  - Signed ops (MULT/DIV) latch the absolute values of the operands, plus result-sign flags:
    - product/quotient sign = a[MSB] ^ b[MSB];
    - remainder sign = a[MSB].
  - Unsigned ops latch the operands unchanged.
- **Multiply:** shift-add, one multiplier bit per CALC cycle, into a 2·WIDTH accumulator.
- **Divide:** restoring division, one quotient bit per CALC cycle; the partial remainder is WIDTH+1 bits.
- **FIX:**
  - Apply two's-complement negation per the sign flags.
  - Write HI/LO: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- **Divide by zero:**
  - No trap, same latency.
  - Result is HI = `operand_a` as latched (original signed value for DIV), LO = all ones, for both DIV and DIVU.
- **Signed overflow** (DIV 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This falls out of the magnitude arithmetic.
- **MTHI/MTLO:**
  - In IDLE, take effect at the next posedge; `hi_we` and `lo_we` may be asserted together.
  - While `busy`, they are ignored.
- **Start while busy:** ignored, no queueing.
- **start and hi_we/lo_we in the same IDLE cycle:** both take effect. The write updates HI/LO now, and the result overwrites them at FIX.
- **Reset mid-operation:** abort, everything returns to reset values, and no `done` is produced.

## Timing
- `start` is sampled at edge 0.
- `busy` = 1 from after edge 0 through edge WIDTH+1, i.e. CALC plus FIX: 33 cycles at `WIDTH` = 32.
- HI/LO update at edge WIDTH+1.
- `done` = 1 for exactly one cycle, after edge WIDTH+1. During that cycle `busy` = 0 and a new `start` is accepted.
- Start-to-done latency is WIDTH+2 = 34 cycles.
- `hi_out`/`lo_out` change only at reset, at FIX, or on an accepted MTHI/MTLO.

## Configuration
- `MULT_DIV_FAST_MUL_EN` defined:
  - MULT/MULTU compute the full product combinationally at load.
  - The product is latched, and the unit goes straight to FIX, skipping CALC.
  - `busy` lasts 1 cycle and `done` follows 2 cycles after `start`.
  - Division is unchanged.
- Macro undefined: all operations are iterative, as described in Operation and Timing.

## Structure
- **Shared package `mips_pkg`:**
  - op encodings: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - state encoding: `MDU_IDLE`, `MDU_CALC`, `MDU_FIX`;
  - `MDU_ITER` = WIDTH.
- **Sub-module `mdu_sign_fix`:** combinational conditional two's-complement negate, parameterised by width. It is instantiated for operand abs at load and for result correction at FIX.

## Test plan
- MULTU a=0xFFFFFFFF, b=2 → done at cycle 34; HI=0x00000001, LO=0xFFFFFFFE.
- MULT a=0xFFFFFFFF (−1), b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=7 → LO=14, HI=2.
- DIVU a=5, b=0 → HI=5, LO=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100/7, then at cycle 10 pulse `start` with MULTU 3×3, then pulse `hi_we` with 0x1234 → both ignored, busy unchanged, result as above.
- DIVU 100/7 started, then `reset`=0 at cycle 10 → busy=0 and HI=LO=0 immediately, no done pulse. After release, MTLO 0xABCD gives lo_out=0xABCD at the next edge.
